// File: rtl/gfx_pkg.sv
// Shared graphics types and constants: fp32 literals, vector/matrix types and
// the vertex transform FSM encoding.
package gfx_pkg;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;
    localparam int          DOT_LAT   = 3;

    typedef logic [2:0][31:0] vec3_t;
    typedef logic [3:0][31:0] vec4_t;
    typedef vec4_t            mat4_t [4];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_COLLECT,
        ST_HOLD
    } vt_state_e;

endpackage

// File: rtl/fp32_dot.sv
// Pipelined 4-term fp32 dot product, DOT_LAT cycles valid_in -> valid_out.
// Single truncating rounding after an aligned fixed-point sum; denormals flush to zero.
module fp32_dot
    import gfx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  vec4_t       a,
    input  vec4_t       b,
    output logic        valid_out,
    output logic [31:0] result
);
    localparam int STAGES = DOT_LAT;

    logic [STAGES-1:0] vld_pipe;
    logic [3:0]        p_sign;
    logic [3:0][9:0]   p_exp;
    logic [3:0][47:0]  p_man;
    logic              s_sign;
    logic [9:0]        s_emax;
    logic [49:0]       s_mag;

    logic [9:0]         emax_c, diff_c;
    logic [47:0]        term_c;
    logic signed [50:0] sum_c;
    int                 lead_c, exp_c;
    logic [22:0]        frac_c;
    logic [31:0]        res_c;

    // Products are summed against the largest exponent so cancellation stays exact.
    always_comb begin
        emax_c = '0;
        diff_c = '0;
        term_c = '0;
        sum_c  = '0;
        for (int i = 0; i < 4; i++)
            if (p_exp[i] > emax_c) emax_c = p_exp[i];
        for (int i = 0; i < 4; i++) begin
            diff_c = emax_c - p_exp[i];
            term_c = (diff_c > 10'd47) ? '0 : (p_man[i] >> diff_c);
            if (p_sign[i]) sum_c = sum_c - $signed({3'b000, term_c});
            else           sum_c = sum_c + $signed({3'b000, term_c});
        end
    end

    always_comb begin
        lead_c = 0;
        for (int i = 0; i < 50; i++)
            if (s_mag[i]) lead_c = i;
        exp_c  = lead_c + int'(s_emax) - 173;
        frac_c = 23'((s_mag << (49 - lead_c)) >> 26);
        if (s_mag == '0 || exp_c <= 0) res_c = FP32_ZERO;
        else if (exp_c >= 255)         res_c = {s_sign, 8'hFF, 23'd0};
        else                           res_c = {s_sign, exp_c[7:0], frac_c};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            p_sign   <= '0;
            p_exp    <= '0;
            p_man    <= '0;
            s_sign   <= 1'b0;
            s_emax   <= '0;
            s_mag    <= '0;
            result   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-2:0], valid_in};
            for (int i = 0; i < 4; i++) begin
                p_sign[i] <= a[i][31] ^ b[i][31];
                if (a[i][30:23] == 8'd0 || b[i][30:23] == 8'd0) begin
                    p_exp[i] <= '0;
                    p_man[i] <= '0;
                end else begin
                    p_exp[i] <= {2'b00, a[i][30:23]} + {2'b00, b[i][30:23]};
                    p_man[i] <= 48'({1'b1, a[i][22:0]}) * 48'({1'b1, b[i][22:0]});
                end
            end
            s_sign <= sum_c[50];
            s_emax <= emax_c;
            s_mag  <= sum_c[50] ? 50'(-sum_c) : sum_c[49:0];
            result <= res_c;
        end
    end

    assign valid_out = vld_pipe[STAGES-1];

endmodule

// File: rtl/vertex_transform.sv
// Applies the streamed 4x4 fp32 matrix to model-space vertices through one shared fp32_dot.
// Optional VERTEX_TRANSFORM_BEHIND_FLAG_EN adds behind_out (clip w <= 0).
module vertex_transform
    import gfx_pkg::*;
#(
    parameter bit IDENTITY_ON_RESET = 1'b1
)
(
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              matrix_valid_in,
    input  logic [3:0][31:0]  matrix_col_in,
    input  logic              vertex_valid_in,
    output logic              vertex_ready_out,
    input  logic [2:0][31:0]  vertex_in,
    output logic              vertex_valid_out,
    input  logic              vertex_ready_in,
    output logic [3:0][31:0]  vertex_out
`ifdef VERTEX_TRANSFORM_BEHIND_FLAG_EN
    ,
    output logic              behind_out
`endif
);
    vt_state_e   state, state_nxt;
    mat4_t       shadow;   // shadow[c] = column c as streamed
    mat4_t       active;   // active[r] = row r, fed straight to the dot unit
    vec4_t       vin;
    logic [1:0]  beat_cnt, issue_cnt, res_cnt;
    logic        commit_pending, matrix_loaded, commit, accept;
    logic        dot_valid, dot_valid_out;
    logic [31:0] dot_result;

    assign accept = vertex_valid_in & vertex_ready_out;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept) state_nxt = ST_ISSUE;
            ST_ISSUE:   if (issue_cnt == 2'd3) state_nxt = ST_COLLECT;
            ST_COLLECT: if (dot_valid_out && res_cnt == 2'd3) state_nxt = ST_HOLD;
            ST_HOLD:    if (vertex_ready_in) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Commit only in Idle, so an in-flight vertex never sees a matrix swap.
    always_comb begin
        vertex_ready_out = 1'b0;
        commit           = 1'b0;
        dot_valid        = 1'b0;
        case (state)
            ST_IDLE: begin
                commit           = commit_pending;
                vertex_ready_out = ~commit_pending & matrix_loaded;
            end
            ST_ISSUE: dot_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            beat_cnt       <= '0;
            commit_pending <= 1'b0;
            matrix_loaded  <= IDENTITY_ON_RESET;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    shadow[r][c] <= FP32_ZERO;
                    active[r][c] <= (IDENTITY_ON_RESET && r == c) ? FP32_ONE : FP32_ZERO;
                end
        end else begin
            if (matrix_valid_in) begin
                shadow[beat_cnt] <= matrix_col_in;
                beat_cnt         <= beat_cnt + 2'd1;
            end
            if (commit) begin
                matrix_loaded <= 1'b1;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        active[r][c] <= shadow[c][r];
            end
            // A fresh final beat outranks the clear: the newer set commits next.
            if (matrix_valid_in && beat_cnt == 2'd3) commit_pending <= 1'b1;
            else if (commit)                         commit_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vin              <= '0;
            issue_cnt        <= '0;
            res_cnt          <= '0;
            vertex_out       <= '0;
            vertex_valid_out <= 1'b0;
`ifdef VERTEX_TRANSFORM_BEHIND_FLAG_EN
            behind_out       <= 1'b0;
`endif
        end else begin
            if (accept)
                vin <= {FP32_ONE, vertex_in};
            if (dot_valid)
                issue_cnt <= issue_cnt + 2'd1;
            if (dot_valid_out) begin
                vertex_out[res_cnt] <= dot_result;
                res_cnt             <= res_cnt + 2'd1;
                if (res_cnt == 2'd3) begin
                    vertex_valid_out <= 1'b1;
`ifdef VERTEX_TRANSFORM_BEHIND_FLAG_EN
                    behind_out <= dot_result[31] | (dot_result[30:0] == 31'd0);
`endif
                end
            end
            if (state == ST_HOLD && vertex_ready_in)
                vertex_valid_out <= 1'b0;
        end
    end

    fp32_dot u_dot (
        .clk       (clk_in),
        .rst       (~rst_n_in),
        .valid_in  (dot_valid),
        .a         (active[issue_cnt]),
        .b         (vin),
        .valid_out (dot_valid_out),
        .result    (dot_result)
    );

endmodule

// File: tb/tb_vertex_transform.sv
// Scoreboard bench for vertex_transform: integer-valued matrices/vertices keep the
// expected fp32 results exact; a monitor pops expectations on each output handshake.
module tb_vertex_transform;
    import gfx_pkg::*;

    logic  clk_in = 1'b0;
    logic  rst_n_in = 1'b0;
    logic  matrix_valid_in = 1'b0;
    vec4_t matrix_col_in = '0;
    logic  vertex_valid_in = 1'b0;
    logic  vertex_ready_out;
    vec3_t vertex_in = '0;
    logic  vertex_valid_out;
    logic  vertex_ready_in = 1'b1;
    vec4_t vertex_out;
    logic  rdy0, vld0;
    vec4_t out0;
`ifdef VERTEX_TRANSFORM_BEHIND_FLAG_EN
    logic  behind_out, behind0;
`endif

    typedef struct {
        vec4_t v;
        logic  behind;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    int   mdl_act[4][4];
    int   mdl_shadow[4][4];
    int   mdl_beat = 0;
    int   ld[4][4];
    bit   hold_low = 1'b0;
    bit   rand_bp  = 1'b0;

    always #5 clk_in = ~clk_in;

    vertex_transform u_dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .matrix_valid_in(matrix_valid_in), .matrix_col_in(matrix_col_in),
        .vertex_valid_in(vertex_valid_in), .vertex_ready_out(vertex_ready_out),
        .vertex_in(vertex_in), .vertex_valid_out(vertex_valid_out),
        .vertex_ready_in(vertex_ready_in), .vertex_out(vertex_out)
`ifdef VERTEX_TRANSFORM_BEHIND_FLAG_EN
        , .behind_out(behind_out)
`endif
    );

    vertex_transform #(.IDENTITY_ON_RESET(1'b0)) u_dut0 (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .matrix_valid_in(matrix_valid_in), .matrix_col_in(matrix_col_in),
        .vertex_valid_in(1'b0), .vertex_ready_out(rdy0),
        .vertex_in(vertex_in), .vertex_valid_out(vld0),
        .vertex_ready_in(1'b1), .vertex_out(out0)
`ifdef VERTEX_TRANSFORM_BEHIND_FLAG_EN
        , .behind_out(behind0)
`endif
    );

    function automatic logic [31:0] to_fp(input int n);
        int mag, p;
        logic [31:0] f;
        if (n == 0) return 32'h0;
        mag = (n < 0) ? -n : n;
        p = 0;
        for (int i = 0; i < 31; i++)
            if (mag >= (1 << i)) p = i;
        f = 32'(mag) << (23 - p);
        return {n < 0, 8'(127 + p), f[22:0]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic set_identity();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                ld[r][c] = (r == c) ? 1 : 0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                mdl_act[r][c]    = (r == c) ? 1 : 0;
                mdl_shadow[r][c] = 0;
            end
        mdl_beat = 0;
    endtask

    // Streams columns of ld; the model adopts a matrix once its fourth column lands.
    task automatic send_beats(input int first, input int last);
        for (int c = first; c <= last; c++) begin
            matrix_valid_in = 1'b1;
            for (int i = 0; i < 4; i++) begin
                matrix_col_in[i]         = to_fp(ld[i][c]);
                mdl_shadow[i][mdl_beat]  = ld[i][c];
            end
            if (mdl_beat == 3) mdl_act = mdl_shadow;
            mdl_beat = (mdl_beat + 1) % 4;
            @(posedge clk_in); #1;
        end
        matrix_valid_in = 1'b0;
    endtask

    task automatic send_vertex(input int x, input int y, input int z);
        exp_t e;
        int   cyc, acc;
        bit   got;
        vertex_in       = {to_fp(z), to_fp(y), to_fp(x)};
        vertex_valid_in = 1'b1;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 200) begin
            @(negedge clk_in);
            if (vertex_ready_out) got = 1'b1;
            cyc++;
        end
        if (!got) begin
            timeout_fail("vertex_accept");
            vertex_valid_in = 1'b0;
            return;
        end
        @(posedge clk_in); #1;
        vertex_valid_in = 1'b0;
        for (int r = 0; r < 4; r++) begin
            acc = mdl_act[r][0] * x + mdl_act[r][1] * y + mdl_act[r][2] * z + mdl_act[r][3];
            e.v[r] = to_fp(acc);
            if (r == 3) e.behind = (acc <= 0);
        end
        sb.push_back(e);
    endtask

    task automatic drain();
        int cyc = 0;
        while (sb.size() != 0 && cyc < 500) begin
            @(posedge clk_in);
            cyc++;
        end
        if (sb.size() != 0) begin
            timeout_fail("drain");
            sb.delete();
        end
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk_in); #1;
            vertex_ready_in = hold_low ? 1'b0 : (rand_bp ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Monitor: pops on every output handshake and checks stability while stalled.
    initial begin
        exp_t  e;
        vec4_t prev_v;
        bit    prev_hold;
        prev_v = '0;
        prev_hold = 1'b0;
        forever begin
            @(negedge clk_in);
            if (!rst_n_in) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", vertex_valid_out, 1'b1);
                    check("hold_stable", vertex_out, prev_v);
                end
                prev_hold = 1'b0;
                if (vertex_valid_out && vertex_ready_in) begin
                    if (sb.size() == 0) begin
                        timeout_fail("unexpected_result");
                    end else begin
                        e = sb.pop_front();
                        check("vertex_out", vertex_out, e.v);
`ifdef VERTEX_TRANSFORM_BEHIND_FLAG_EN
                        check("behind_out", behind_out, e.behind);
`endif
                    end
                end else if (vertex_valid_out) begin
                    prev_hold = 1'b1;
                    prev_v    = vertex_out;
                end
            end
        end
    end

    initial begin
        int cyc;
        model_reset();
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_valid", vertex_valid_out, 1'b0);
        check("rst_out", vertex_out, '0);
        check("rst_ready", vertex_ready_out, 1'b1);
        check("rst_ready_zero_matrix", rdy0, 1'b0);
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;

        // Identity matrix straight out of reset.
        send_vertex(1, 2, 3);
        drain();
        check("identity_const", vertex_out, 128'h3F800000_40400000_40000000_3F800000);

        // Translation by +5 in x.
        set_identity();
        ld[0][3] = 5;
        send_beats(0, 3);
        send_vertex(1, 2, 3);
        drain();
        check("translate_x", vertex_out[0], 32'h40C00000);
        check("zero_matrix_ready_after_commit", rdy0, 1'b1);

        // Downstream stall for 10 cycles.
        hold_low = 1'b1;
        send_vertex(2, -1, 4);
        cyc = 0;
        while (!vertex_valid_out && cyc < 100) begin
            @(posedge clk_in); #1;
            cyc++;
        end
        if (!vertex_valid_out) timeout_fail("hold_wait");
        repeat (10) begin
            @(negedge clk_in);
            check("hold_no_accept", vertex_ready_out, 1'b0);
        end
        hold_low = 1'b0;
        drain();

        // New matrix streamed while a vertex is in flight.
        send_vertex(1, 1, 1);
        repeat (4) @(posedge clk_in);
        #1;
        set_identity();
        for (int i = 0; i < 3; i++) ld[i][i] = 2;
        send_beats(0, 3);
        send_vertex(1, 1, 1);
        drain();
        check("scale_const", vertex_out, 128'h3F800000_40000000_40000000_40000000);

        // Randomized matrices and vertices with random backpressure.
        rand_bp = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        ld[r][c] = $urandom_range(0, 8) - 4;
                send_beats(0, 3);
            end
            send_vertex($urandom_range(0, 16) - 8, $urandom_range(0, 16) - 8,
                        $urandom_range(0, 16) - 8);
        end
        rand_bp = 1'b0;
        drain();

        // Asynchronous reset mid-Issue with a partial matrix in the shadow.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                ld[r][c] = r + c - 2;
        send_beats(0, 1);
        send_vertex(1, 2, 3);
        repeat (2) @(posedge clk_in);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("async_rst_valid", vertex_valid_out, 1'b0);
        check("async_rst_out", vertex_out, '0);
        check("async_rst_ready", vertex_ready_out, 1'b1);
        check("async_rst_ready_zero_matrix", rdy0, 1'b0);
        sb.delete();
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                ld[r][c] = 3 - r + c;
        send_beats(0, 1);
        repeat (3) @(posedge clk_in);
        #1;
        check("partial_no_commit", rdy0, 1'b0);
        send_vertex(3, -2, 5);
        send_beats(2, 3);
        send_vertex(3, -2, 5);
        drain();

        // Clip w sign: row3 = (0,0,-1,0).
        set_identity();
        ld[3][2] = -1;
        ld[3][3] = 0;
        send_beats(0, 3);
        send_vertex(0, 0, 3);
        send_vertex(0, 0, -3);
        drain();
        check("w_positive_const", vertex_out[3], 32'h40400000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
